// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Detects a runtime-programmable PAT_W-bit serial pattern on a valid-qualified
//   bit stream. It supports overlapping and non-overlapping match modes. The
//   detect pulse is registered (Moore-style). A saturating hit counter and a
//   fill/progress output are provided for debug.
//
// Ports
//   clk_i      in   clock, all logic on posedge
//   clr_i      in   synchronous active-low reset, overrides every other input
//   valid_i    in   input_i is sampled only when high
//   input_i    in   serial data bit
//   cfg_we_i   in   configuration write strobe (wins over valid_i)
//   cfg_pat_i  in   new pattern, loaded on cfg_we_i
//   cfg_ovl_i  in   new overlap mode, loaded on cfg_we_i (1 = overlapping)
//   cnt_clr_i  in   clears the hit counter (a same-cycle hit still counts)
//   out        out  detect pulse, high for one cycle per hit
//   count_o    out  saturating hit count
//   fill_o     out  valid bits accumulated toward the current match window
//   pat_o      out  active pattern
//   ovl_o      out  active overlap mode
//   state_o    out  one-hot window state {ARMED, FILL, IDLE}, for debug
//
// Stream handshake: there is no back-pressure. A bit is transferred on every
// posedge where valid_i=1 and cfg_we_i=0. A bit presented together with
// cfg_we_i is dropped.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
  parameter bit               OVL_RST = 1'b0,
  parameter int               CNT_W   = 16,
  localparam int              FILL_W  = $clog2(PAT_W + 1)
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic              input_i,
  input  logic              cfg_we_i,
  input  logic [PAT_W-1:0]  cfg_pat_i,
  input  logic              cfg_ovl_i,
  input  logic              cnt_clr_i,
  output logic              out,
  output logic [CNT_W-1:0]  count_o,
  output logic [FILL_W-1:0] fill_o,
  output logic [PAT_W-1:0]  pat_o,
  output logic              ovl_o,
  output logic [2:0]        state_o
);

  // IDLE: window empty. FILL: partially filled. ARMED: window full, so every
  // accepted bit is a match candidate. ARMED persists across hits only in
  // overlap mode. A non-overlapping hit empties the window.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_FILL  = 3'b010,
    S_ARMED = 3'b100
  } state_t;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t              r_state;
  logic [PAT_W-1:0]    r_hist;
  logic [FILL_W-1:0]   r_fill;
  logic                r_out;
  logic [CNT_W-1:0]    r_count;
  logic [PAT_W-1:0]    r_pat;
  logic                r_ovl;

  state_t              w_state_next;
  logic [PAT_W-1:0]    w_hist_n;
  logic [FILL_W-1:0]   w_fill_n;
  logic                w_accept;
  logic                w_hit;
  logic [PAT_W-1:0]    w_hist_next;
  logic [FILL_W-1:0]   w_fill_next;
  logic [PAT_W-1:0]    w_pat_next;
  logic                w_ovl_next;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [CNT_W-1:0]    w_count_next;

  always_comb begin
    w_hist_n     = {r_hist[PAT_W-2:0], input_i};
    w_fill_n     = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
    w_accept     = valid_i & ~cfg_we_i;
    w_hit        = w_accept && (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);

    w_hist_next  = r_hist;
    w_fill_next  = r_fill;
    w_pat_next   = r_pat;
    w_ovl_next   = r_ovl;
    w_state_next = r_state;

    if (cfg_we_i) begin
      // A new config always flushes the window, so no partial match spans a
      // pattern or mode change.
      w_pat_next  = cfg_pat_i;
      w_ovl_next  = cfg_ovl_i;
      w_hist_next = '0;
      w_fill_next = '0;
    end else if (valid_i) begin
      // hist keeps shifting even after a non-overlapping hit. Only the fill
      // count is reset, which keeps the matched bits out of the next window.
      w_hist_next = w_hist_n;
      w_fill_next = (w_hit && !r_ovl) ? '0 : w_fill_n;
    end

    if (w_fill_next == '0) begin
      w_state_next = S_IDLE;
    end else if (w_fill_next == FILL_FULL) begin
      w_state_next = S_ARMED;
    end else begin
      w_state_next = S_FILL;
    end

    // Clear and hit together yield 1.
    w_cnt_base   = cnt_clr_i ? '0 : r_count;
    w_count_next = (w_hit && (w_cnt_base != CNT_MAX)) ? w_cnt_base + CNT_W'(1)
                                                      : w_cnt_base;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      r_state <= S_IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_out   <= 1'b0;
      r_count <= '0;
      r_pat   <= PAT_RST;
      r_ovl   <= OVL_RST;
    end else begin
      r_state <= w_state_next;
      r_hist  <= w_hist_next;
      r_fill  <= w_fill_next;
      r_out   <= w_hit;
      r_count <= w_count_next;
      r_pat   <= w_pat_next;
      r_ovl   <= w_ovl_next;
    end
  end

  assign out     = r_out;
  assign count_o = r_count;
  assign fill_o  = r_fill;
  assign pat_o   = r_pat;
  assign ovl_o   = r_ovl;
  assign state_o = r_state;

endmodule
